// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// wb_pkg : register-address constants and helpers for the writeback arbiter
// Revision: 1.0
// ============================================================================
package wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    function automatic logic [NUM_REGS-1:0] addr_onehot(input reg_addr_t addr);
        logic [NUM_REGS-1:0] mask;
        mask = NUM_REGS'(1) << addr;
        return mask;
    endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter_if : source-side handshakes plus register-file write bus
// Revision: 1.0
// ============================================================================
interface regfile_wb_arbiter_if
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int NR_SOURCES     = 4,
    parameter int NR_WRITE_PORTS = 2
);

    logic [NR_SOURCES-1:0]                      src_valid_i;
    logic [NR_SOURCES-1:0]                      src_ready_o;
    reg_addr_t [NR_SOURCES-1:0]                 src_waddr_i;
    logic [NR_SOURCES-1:0][DATA_WIDTH-1:0]      src_wdata_i;

    logic [NR_WRITE_PORTS-1:0]                  we_o;
    reg_addr_t [NR_WRITE_PORTS-1:0]             waddr_o;
    logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wdata_o;
    logic [NUM_REGS-1:0]                        pending_o;

    modport slave (
        input  src_valid_i, src_waddr_i, src_wdata_i,
        output src_ready_o, we_o, waddr_o, wdata_o, pending_o
    );

    modport master (
        output src_valid_i, src_waddr_i, src_wdata_i,
        input  src_ready_o, we_o, waddr_o, wdata_o, pending_o
    );

endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter_rr_select.sv
`default_nettype none
// ============================================================================
// wb_rr_select : round-robin multi-grant picker that never grants two sources
//                targeting the same register in one cycle
// Revision: 1.0
// ============================================================================
module wb_rr_select
    import wb_pkg::*;
#(
    parameter int NR_SOURCES     = 4,
    parameter int NR_WRITE_PORTS = 2,
    parameter int PTR_W          = 2
) (
    input  logic [NR_SOURCES-1:0]                  full_i,
    input  reg_addr_t [NR_SOURCES-1:0]             addr_i,
    input  logic [PTR_W-1:0]                       rr_ptr_i,
    output logic [NR_SOURCES-1:0]                  grant_o,
    output logic [NR_WRITE_PORTS-1:0]              port_valid_o,
    output logic [NR_WRITE_PORTS-1:0][PTR_W-1:0]   port_src_o,
    output logic [PTR_W-1:0]                       rr_ptr_next_o
);

    reg_addr_t used_addr [NR_WRITE_PORTS];
    int        n_granted;
    logic      clash;

    // Outer loop is scan position, inner loop finds the source at that
    // position, so every array index stays a loop constant.
    always_comb begin
        grant_o       = '0;
        port_valid_o  = '0;
        port_src_o    = '0;
        rr_ptr_next_o = rr_ptr_i;
        n_granted     = 0;
        clash         = 1'b0;
        for (int k = 0; k < NR_WRITE_PORTS; k++) begin
            used_addr[k] = '0;
        end

        for (int i = 0; i < NR_SOURCES; i++) begin
            for (int j = 0; j < NR_SOURCES; j++) begin
                if (((j + NR_SOURCES - int'(rr_ptr_i)) % NR_SOURCES) == i) begin
                    if (full_i[j] && (n_granted < NR_WRITE_PORTS)) begin
                        clash = 1'b0;
                        for (int k = 0; k < NR_WRITE_PORTS; k++) begin
                            if ((k < n_granted) && (used_addr[k] == addr_i[j])) begin
                                clash = 1'b1;
                            end
                        end
                        if (!clash) begin
                            grant_o[j] = 1'b1;
                            for (int k = 0; k < NR_WRITE_PORTS; k++) begin
                                if (k == n_granted) begin
                                    port_valid_o[k] = 1'b1;
                                    port_src_o[k]   = PTR_W'(j);
                                    used_addr[k]    = addr_i[j];
                                end
                            end
                            n_granted     = n_granted + 1;
                            rr_ptr_next_o = PTR_W'((j + 1) % NR_SOURCES);
                        end
                    end
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// regfile_wb_arbiter : single-entry buffer per functional-unit result, drained
//                      round-robin onto registered register-file write ports
// Revision: 1.0
// ============================================================================
module regfile_wb_arbiter
    import wb_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int NR_SOURCES     = 4,
    parameter int NR_WRITE_PORTS = 2,
    parameter bit DROP_X0        = 1'b1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    regfile_wb_arbiter_if.slave  bus
);

    localparam int PTR_W = (NR_SOURCES > 1) ? $clog2(NR_SOURCES) : 1;

    typedef struct packed {
        reg_addr_t             waddr;
        logic [DATA_WIDTH-1:0] wdata;
    } wb_req_t;

    logic [NR_SOURCES-1:0]                 full_d, full_q;
    wb_req_t [NR_SOURCES-1:0]              buf_d, buf_q;
    logic [PTR_W-1:0]                      rr_ptr_d, rr_ptr_q;
    logic [NR_WRITE_PORTS-1:0]             we_d, we_q;
    wb_req_t [NR_WRITE_PORTS-1:0]          port_d, port_q;

    logic [NR_SOURCES-1:0]                 grant;
    logic [NR_SOURCES-1:0]                 src_ready;
    logic [NR_SOURCES-1:0]                 xfer;
    reg_addr_t [NR_SOURCES-1:0]            buf_addr;
    logic [NR_WRITE_PORTS-1:0]             port_valid;
    logic [NR_WRITE_PORTS-1:0][PTR_W-1:0]  port_src;
    logic [PTR_W-1:0]                      rr_ptr_next;
    logic [NUM_REGS-1:0]                   pending;

    always_comb begin
        for (int i = 0; i < NR_SOURCES; i++) begin
            buf_addr[i] = buf_q[i].waddr;
        end
    end

    wb_rr_select #(
        .NR_SOURCES     (NR_SOURCES),
        .NR_WRITE_PORTS (NR_WRITE_PORTS),
        .PTR_W          (PTR_W)
    ) u_select (
        .full_i        (full_q),
        .addr_i        (buf_addr),
        .rr_ptr_i      (rr_ptr_q),
        .grant_o       (grant),
        .port_valid_o  (port_valid),
        .port_src_o    (port_src),
        .rr_ptr_next_o (rr_ptr_next)
    );

    // A buffer being drained this cycle can accept a new result at once.
    assign src_ready = ~full_q | grant;
    assign xfer      = bus.src_valid_i & src_ready;

    always_comb begin
        full_d = full_q & ~grant;
        buf_d  = buf_q;
        for (int i = 0; i < NR_SOURCES; i++) begin
            if (xfer[i] && !(DROP_X0 && (bus.src_waddr_i[i] == '0))) begin
                full_d[i]       = 1'b1;
                buf_d[i].waddr  = bus.src_waddr_i[i];
                buf_d[i].wdata  = bus.src_wdata_i[i];
            end
        end
    end

    always_comb begin
        we_d     = port_valid;
        port_d   = port_q;
        rr_ptr_d = rr_ptr_next;
        for (int k = 0; k < NR_WRITE_PORTS; k++) begin
            for (int j = 0; j < NR_SOURCES; j++) begin
                if (port_valid[k] && (port_src[k] == PTR_W'(j))) begin
                    port_d[k] = buf_q[j];
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            full_q   <= '0;
            buf_q    <= '0;
            rr_ptr_q <= '0;
            we_q     <= '0;
            port_q   <= '0;
        end else begin
            full_q   <= full_d;
            buf_q    <= buf_d;
            rr_ptr_q <= rr_ptr_d;
            we_q     <= we_d;
            port_q   <= port_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < NR_SOURCES; i++) begin
            if (full_q[i]) begin
                pending = pending | addr_onehot(buf_q[i].waddr);
            end
        end
        for (int k = 0; k < NR_WRITE_PORTS; k++) begin
            if (we_q[k]) begin
                pending = pending | addr_onehot(port_q[k].waddr);
            end
        end
        if (DROP_X0) begin
            pending[0] = 1'b0;
        end
    end

    always_comb begin
        for (int k = 0; k < NR_WRITE_PORTS; k++) begin
            bus.waddr_o[k] = port_q[k].waddr;
            bus.wdata_o[k] = port_q[k].wdata;
        end
    end

    assign bus.src_ready_o = src_ready;
    assign bus.we_o        = we_q;
    assign bus.pending_o   = pending;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// tb_regfile_wb_arbiter : directed scenarios plus random traffic, scored by
//                         per-source expected-write queues
// Revision: 1.0
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int NS = 4;
    localparam int NP = 2;
    localparam int DW = 64;

    typedef struct {
        logic [4:0]    a;
        logic [DW-1:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    regfile_wb_arbiter_if #(.DATA_WIDTH(DW), .NR_SOURCES(NS), .NR_WRITE_PORTS(NP)) bus ();

    regfile_wb_arbiter #(
        .DATA_WIDTH     (DW),
        .NR_SOURCES     (NS),
        .NR_WRITE_PORTS (NP),
        .DROP_X0        (1'b1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    exp_t          sbq [NS][$];
    int            checks   = 0;
    int            failures = 0;
    bit            mon_en   = 1'b0;
    logic [NS-1:0] xfer;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic drive(int s, bit v, logic [4:0] a, logic [DW-1:0] d);
        bus.src_valid_i[s] = v;
        bus.src_waddr_i[s] = a;
        bus.src_wdata_i[s] = d;
    endtask

    // Called at a negedge with inputs set; returns at the following negedge.
    task automatic cycle();
        #1;
        xfer = bus.src_valid_i & bus.src_ready_o;
        @(posedge clk);
        for (int s = 0; s < NS; s++) begin
            if (rst) begin
                sbq[s].delete();
            end else if (xfer[s] && (bus.src_waddr_i[s] != 5'd0)) begin
                sbq[s].push_back('{bus.src_waddr_i[s], bus.src_wdata_i[s]});
            end
        end
        @(negedge clk);
    endtask

    task automatic idle_all();
        for (int s = 0; s < NS; s++) bus.src_valid_i[s] = 1'b0;
    endtask

    task automatic do_reset();
        idle_all();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    function automatic int outstanding();
        int n = 0;
        for (int s = 0; s < NS; s++) n += sbq[s].size();
        return n;
    endfunction

    // Monitor: pending mask from the queues, every write matched to its source.
    always @(negedge clk) begin
        logic [31:0] ep;
        logic [1:0]  src;
        exp_t        e;
        if (mon_en) begin
            ep = '0;
            for (int s = 0; s < NS; s++)
                for (int i = 0; i < sbq[s].size(); i++)
                    ep = ep | (32'd1 << sbq[s][i].a);
            chk("pending", bus.pending_o, ep);
            for (int k = 0; k < NP; k++) begin
                if (bus.we_o[k]) begin
                    src = bus.wdata_o[k][DW-1:DW-2];
                    if (sbq[src].size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write: port%0d addr=%0d data=%0h, required no write",
                                 k, bus.waddr_o[k], bus.wdata_o[k]);
                    end else begin
                        e = sbq[src].pop_front();
                        chk("wr_addr", bus.waddr_o[k], e.a);
                        chk("wr_data", bus.wdata_o[k], e.d);
                    end
                    for (int j = 0; j < k; j++)
                        chk("port_addr_conflict",
                            64'(bus.we_o[j] && (bus.waddr_o[j] == bus.waddr_o[k])), 64'd0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    bit            busy [NS];
    logic [DW-1:0] da, db;
    int            guard;

    initial begin
        bus.src_valid_i = '0;
        bus.src_waddr_i = '0;
        bus.src_wdata_i = '0;
        @(negedge clk);
        do_reset();
        do_reset();
        mon_en = 1'b1;

        // Reset then idle
        chk("rst_ready", bus.src_ready_o, 4'hF);
        chk("rst_we", bus.we_o, 2'b00);
        chk("rst_pending", bus.pending_o, 32'd0);

        // Single write latency
        drive(0, 1'b1, 5'd5, 64'hDEAD);
        cycle();
        idle_all();
        chk("single_pending", bus.pending_o, 32'h20);
        chk("single_we_early", bus.we_o, 2'b00);
        cycle();
        chk("single_we", bus.we_o, 2'b01);
        chk("single_waddr", bus.waddr_o[0], 5'd5);
        chk("single_wdata", bus.wdata_o[0], 64'hDEAD);
        cycle();
        chk("single_done_we", bus.we_o, 2'b00);
        chk("single_done_pending", bus.pending_o, 32'd0);

        // All four full, rr_ptr from 0
        do_reset();
        for (int s = 0; s < NS; s++) drive(s, 1'b1, 5'(s + 1), {2'(s), 62'h100 + 62'(s)});
        cycle();
        chk("rr_ready_A", bus.src_ready_o, 4'b0011);
        idle_all();
        cycle();
        chk("rr_A_we", bus.we_o, 2'b11);
        chk("rr_A_addr0", bus.waddr_o[0], 5'd1);
        chk("rr_A_addr1", bus.waddr_o[1], 5'd2);
        chk("rr_A_data1", bus.wdata_o[1], {2'd1, 62'h101});
        cycle();
        chk("rr_B_we", bus.we_o, 2'b11);
        chk("rr_B_addr0", bus.waddr_o[0], 5'd3);
        chk("rr_B_addr1", bus.waddr_o[1], 5'd4);
        cycle();
        chk("rr_idle_we", bus.we_o, 2'b00);
        // Pointer wrapped to 0: src0 must take port 0 ahead of src3
        drive(3, 1'b1, 5'd10, {2'd3, 62'h33});
        drive(0, 1'b1, 5'd11, {2'd0, 62'h44});
        cycle();
        idle_all();
        cycle();
        chk("rr_wrap_we", bus.we_o, 2'b11);
        chk("rr_wrap_addr0", bus.waddr_o[0], 5'd11);
        chk("rr_wrap_addr1", bus.waddr_o[1], 5'd10);
        cycle();

        // Address conflict with rr_ptr=1
        do_reset();
        drive(0, 1'b1, 5'd9, {2'd0, 62'h9});
        cycle();
        idle_all();
        cycle();
        cycle();
        da = {2'd1, 62'hAAAA};
        db = {2'd2, 62'hBBBB};
        drive(1, 1'b1, 5'd7, da);
        drive(2, 1'b1, 5'd7, db);
        cycle();
        idle_all();
        chk("conf_ready", bus.src_ready_o, 4'b1011);
        cycle();
        chk("conf_1_we", bus.we_o, 2'b01);
        chk("conf_1_addr", bus.waddr_o[0], 5'd7);
        chk("conf_1_data", bus.wdata_o[0], da);
        cycle();
        chk("conf_2_we", bus.we_o, 2'b01);
        chk("conf_2_addr", bus.waddr_o[0], 5'd7);
        chk("conf_2_data", bus.wdata_o[0], db);
        cycle();
        chk("conf_done_we", bus.we_o, 2'b00);

        // Writes to x0 are swallowed
        drive(3, 1'b1, 5'd0, {2'd3, 62'hFFFF});
        chk("x0_ready", bus.src_ready_o[3], 1'b1);
        cycle();
        idle_all();
        chk("x0_ready_after", bus.src_ready_o[3], 1'b1);
        for (int c = 0; c < 3; c++) begin
            chk("x0_we", bus.we_o, 2'b00);
            chk("x0_pending0", bus.pending_o[0], 1'b0);
            cycle();
        end

        // Reset while three buffers are full
        drive(0, 1'b1, 5'd20, {2'd0, 62'h20});
        drive(1, 1'b1, 5'd21, {2'd1, 62'h21});
        drive(2, 1'b1, 5'd22, {2'd2, 62'h22});
        cycle();
        idle_all();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("midrst_we", bus.we_o, 2'b00);
        chk("midrst_pending", bus.pending_o, 32'd0);
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk("midrst_quiet_we", bus.we_o, 2'b00);
        end

        // Random traffic with a small address pool to provoke conflicts
        for (int s = 0; s < NS; s++) busy[s] = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int s = 0; s < NS; s++) begin
                if (!busy[s] && ($urandom_range(0, 1) == 1)) begin
                    busy[s] = 1'b1;
                    drive(s, 1'b1, 5'($urandom_range(0, 7)),
                          {2'(s), 30'(cyc), 32'($urandom)});
                end
            end
            cycle();
            for (int s = 0; s < NS; s++) begin
                if (xfer[s]) begin
                    busy[s] = 1'b0;
                    bus.src_valid_i[s] = 1'b0;
                end
            end
        end
        idle_all();
        guard = 0;
        while ((guard < 200) && ((outstanding() != 0) || (bus.we_o != '0))) begin
            cycle();
            guard++;
        end
        chk("drain_outstanding", 64'(outstanding()), 64'd0);
        chk("drain_we", bus.we_o, 2'b00);
        chk("drain_pending", bus.pending_o, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
